rf_mrmw: RTL and testbench
==========================

Name: rf_mrmw

Overview:
- Parametrised multi-read, multi-write register file for the RV32E/RV32I core; next generation of the dual-read/dual-write regfile.
- Read and write port counts are set by parameters; reads are registered with 1-cycle latency.
- Adds same-cycle write-conflict resolution, a per-register pending-write scoreboard and an optional write-to-read bypass.
- Sits between decode/issue (read + reserve) and writeback (write ports).

Parameters:
- embedded, 1, 1 = RV32E (16 regs, 4-bit address); 0 = RV32I (32 regs, 5-bit address). Derived raddr_w = embedded ? 4 : 5; NREG = 2**raddr_w.
- NREAD, 2, number of read ports (1..4).
- NWRITE, 2, number of write ports (1..4).
- XLEN, 32, data width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- wr_en  input  NWRITE  per-port write enable
- wr_addr  input  NWRITE*raddr_w  packed write addresses, port i at [i*raddr_w +: raddr_w]
- wr_data  input  NWRITE*XLEN  packed write data, port i at [i*XLEN +: XLEN]
- rd_addr  input  NREAD*raddr_w  packed read addresses
- rd_data  output  NREAD*XLEN  registered read data, port j at [j*XLEN +: XLEN]
- rd_busy  output  NREAD  registered scoreboard busy bit for each read address
- rsv_en  input  1  reserve (mark busy) register rsv_addr
- rsv_addr  input  raddr_w  register to reserve
- wr_conflict  output  1  registered flag: two or more enabled write ports targeted the same nonzero address in the previous cycle

Behaviour:
- Reset (rst=1 at posedge) clears all NREG registers to 0, all busy bits, rd_data, rd_busy and wr_conflict.
  - Reset dominates every same-cycle write, reservation and read.
  - First valid read data appears the cycle after rst deasserts.
- x0 is hardwired:
  - Writes to address 0 are discarded and never count toward wr_conflict.
  - Reads of address 0 return 0 with rd_busy=0.
  - rsv_en with rsv_addr=0 is ignored.
- Write commit: at posedge, for each enabled port with a nonzero address, reg[addr] <= data.
  - Multiple enabled ports on the same address: the highest-index port wins.
  - wr_conflict <= 1 next cycle, otherwise 0. It is a single-cycle pulse per conflicting cycle.
- Read, latency 1: rd_addr sampled at posedge t; rd_data and rd_busy valid from t until posedge t+1.
  - All NREAD ports are independent; any port may read any address, including duplicates.
- Without bypass, reads return the register contents before cycle-t writes (old value).
- Scoreboard, one busy bit per register:
  - rsv_en sets busy[rsv_addr].
  - A committed write to addr clears busy[addr], including the losing ports of a conflict on the same address.
  - rsv_en and a write on the same address in one cycle: the reservation wins and busy stays 1 (a new producer is in flight).
  - Writing a non-busy register is legal and leaves busy at 0.
  - Without bypass, rd_busy reports the busy bit before cycle-t updates.
- No internal stall or backpressure; the issue logic uses rd_busy to stall.
- Implementation: a flop array, not a RAM macro. All outputs are driven from flops.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - rd_data reflects cycle-t writes to the read address, using the same highest-index priority, so the returned value equals the post-commit register.
  - rd_busy reflects the post-update busy bit, i.e. reservation-wins and write-clears both applied.
- Undefined:
  - Pre-update values as described in Behaviour.
  - Writeback-to-read forwarding is then the pipeline's responsibility.
- Port list and latency are identical in both builds.

Test Plan:
- Reset then read all addresses -> every rd_data = 0x00000000, rd_busy = 0, wr_conflict = 0.
- Write port0 x5 = 0xDEADBEEF, port1 x0 = 0x12345678; next cycle read x5 and x0 on both ports -> x5 = 0xDEADBEEF, x0 = 0, wr_conflict = 0.
- Same cycle port0 x3 = 0x11111111, port1 x3 = 0x22222222 -> wr_conflict = 1 for one cycle; subsequent read of x3 = 0x22222222.
- Write x7 = 0xA5A5A5A5 and read x7 in the same cycle -> without RF_BYPASS_EN rd_data = old value 0; with it, 0xA5A5A5A5. Next-cycle read = 0xA5A5A5A5 in both builds.
- rsv_en x9 -> rd_busy = 1 on x9; then write x9 with rsv_en x9 in the same cycle -> busy stays 1; then write x9 alone -> busy = 0.
- Write x4 = 0xCAFEF00D and reserve x6, asserting rst in the same cycle -> x4 reads 0, x6 not busy, all outputs 0.
- Run the set for embedded=0 (address x31) and NREAD=3/NWRITE=3.

Source files
------------

// File: rtl/rf_mrmw.sv
// Parametrised multi-read / multi-write register file with write-conflict flag,
// pending-write scoreboard and optional write-to-read bypass (macro RF_BYPASS_EN).
module rf_mrmw #(
  parameter int embedded = 1,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int XLEN     = 32,
  localparam int raddr_w = (embedded != 0) ? 4 : 5,
  localparam int NREG    = 2 ** raddr_w
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NWRITE-1:0]         wr_en,
  input  logic [NWRITE*raddr_w-1:0] wr_addr,
  input  logic [NWRITE*XLEN-1:0]    wr_data,
  input  logic [NREAD*raddr_w-1:0]  rd_addr,
  output logic [NREAD*XLEN-1:0]     rd_data,
  output logic [NREAD-1:0]          rd_busy,
  input  logic                      rsv_en,
  input  logic [raddr_w-1:0]        rsv_addr,
  output logic                      wr_conflict
);

  logic [XLEN-1:0]       regs_q [NREG];
  logic [XLEN-1:0]       regs_d [NREG];
  logic [NREG-1:0]       busy_q, busy_d;
  logic [NREAD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NREAD-1:0]      rd_busy_q, rd_busy_d;
  logic                  wr_conflict_q, wr_conflict_d;

  always_comb begin
    regs_d        = regs_q;
    busy_d        = busy_q;
    wr_conflict_d = 1'b0;
    rd_data_d     = '0;
    rd_busy_d     = '0;

    // Ascending port order lets the highest-index port win on shared addresses;
    // every committing port still clears the busy bit.
    for (int i = 0; i < NWRITE; i++) begin
      if (wr_en[i] && (wr_addr[i*raddr_w +: raddr_w] != '0)) begin
        regs_d[wr_addr[i*raddr_w +: raddr_w]] = wr_data[i*XLEN +: XLEN];
        busy_d[wr_addr[i*raddr_w +: raddr_w]] = 1'b0;
        for (int k = 0; k < i; k++) begin
          if (wr_en[k] && (wr_addr[k*raddr_w +: raddr_w] == wr_addr[i*raddr_w +: raddr_w])) begin
            wr_conflict_d = 1'b1;
          end
        end
      end
    end

    // Reservation applied after writes so a new in-flight producer keeps busy set.
    if (rsv_en && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end

    for (int j = 0; j < NREAD; j++) begin
      if (rd_addr[j*raddr_w +: raddr_w] != '0) begin
`ifdef RF_BYPASS_EN
        rd_data_d[j*XLEN +: XLEN] = regs_d[rd_addr[j*raddr_w +: raddr_w]];
        rd_busy_d[j]              = busy_d[rd_addr[j*raddr_w +: raddr_w]];
`else
        rd_data_d[j*XLEN +: XLEN] = regs_q[rd_addr[j*raddr_w +: raddr_w]];
        rd_busy_d[j]              = busy_q[rd_addr[j*raddr_w +: raddr_w]];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q        <= '{default: '0};
      busy_q        <= '0;
      rd_data_q     <= '0;
      rd_busy_q     <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      rd_data_q     <= rd_data_d;
      rd_busy_q     <= rd_busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_busy     = rd_busy_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_rf_mrmw.sv
// Self-checking bench for rf_mrmw (RV32I, 3 read / 3 write ports) against a
// behavioural register-file model; follows RF_BYPASS_EN when it is defined.
module tb_rf_mrmw;

  localparam int NR   = 3;
  localparam int NW   = 3;
  localparam int XL   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*XL-1:0]  wr_data;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*XL-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              wr_conflict;

  int checks   = 0;
  int failures = 0;

  // Architectural view: register values and pending-producer flags.
  logic [XL-1:0] mreg  [NREG];
  logic          mbusy [NREG];

  rf_mrmw #(.embedded(0), .NREAD(NR), .NWRITE(NW), .XLEN(XL)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearInputs();
    rst      = 1'b0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic setWrite(input int p, input logic [AW-1:0] a, input logic [XL-1:0] d);
    wr_en[p]             = 1'b1;
    wr_addr[p*AW +: AW]  = a;
    wr_data[p*XL +: XL]  = d;
  endtask

  task automatic setRead(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic reserve(input logic [AW-1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  // Predicts the cycle's results from the architectural rules, clocks once,
  // then compares every output.
  task automatic applyStimulus(input string tag);
    logic [XL-1:0] nreg  [NREG];
    logic          nbusy [NREG];
    int            hits  [NREG];
    logic [XL-1:0] exp_data [NR];
    logic          exp_busy [NR];
    logic          exp_conf;
    logic [AW-1:0] a;

    exp_conf = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      nreg[r]  = mreg[r];
      nbusy[r] = mbusy[r];
      hits[r]  = 0;
    end

    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        nreg[r]  = '0;
        nbusy[r] = 1'b0;
      end
      for (int p = 0; p < NR; p++) begin
        exp_data[p] = '0;
        exp_busy[p] = 1'b0;
      end
    end else begin
      for (int p = 0; p < NW; p++) begin
        a = wr_addr[p*AW +: AW];
        if (wr_en[p] && a != 0) begin
          nreg[a]  = wr_data[p*XL +: XL];
          nbusy[a] = 1'b0;
          hits[a]++;
        end
      end
      if (rsv_en && rsv_addr != 0) nbusy[rsv_addr] = 1'b1;
      for (int r = 0; r < NREG; r++) if (hits[r] > 1) exp_conf = 1'b1;
      for (int p = 0; p < NR; p++) begin
        a = rd_addr[p*AW +: AW];
        if (a == 0) begin
          exp_data[p] = '0;
          exp_busy[p] = 1'b0;
        end else begin
`ifdef RF_BYPASS_EN
          exp_data[p] = nreg[a];
          exp_busy[p] = nbusy[a];
`else
          exp_data[p] = mreg[a];
          exp_busy[p] = mbusy[a];
`endif
        end
      end
    end

    @(posedge clk);
    #1;
    for (int r = 0; r < NREG; r++) begin
      mreg[r]  = nreg[r];
      mbusy[r] = nbusy[r];
    end
    for (int p = 0; p < NR; p++) begin
      checkOutput($sformatf("%s rd_data%0d", tag, p), rd_data[p*XL +: XL], exp_data[p]);
      checkOutput($sformatf("%s rd_busy%0d", tag, p), XL'(rd_busy[p]), XL'(exp_busy[p]));
    end
    checkOutput($sformatf("%s wr_conflict", tag), XL'(wr_conflict), XL'(exp_conf));
    clearInputs();
  endtask

  function automatic logic [AW-1:0] randAddr();
    if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int r = 0; r < NREG; r++) begin
      mreg[r]  = '0;
      mbusy[r] = 1'b0;
    end
    clearInputs();

    rst = 1'b1;
    applyStimulus("reset");
    for (int a = 0; a < NREG; a += NR) begin
      for (int p = 0; p < NR; p++) setRead(p, AW'((a + p) % NREG));
      applyStimulus($sformatf("post-reset x%0d", a));
    end

    setWrite(0, 5'd5, 32'hDEADBEEF);
    setWrite(1, 5'd0, 32'h12345678);
    applyStimulus("write x5/x0");
    setRead(0, 5'd5); setRead(1, 5'd0); setRead(2, 5'd5);
    applyStimulus("read x5/x0");
    checkOutput("x5 value", rd_data[0 +: XL], 32'hDEADBEEF);

    setWrite(0, 5'd3, 32'h11111111);
    setWrite(1, 5'd3, 32'h22222222);
    applyStimulus("conflict x3");
    setRead(0, 5'd3);
    applyStimulus("read x3");
    checkOutput("x3 winner", rd_data[0 +: XL], 32'h22222222);

    setWrite(2, 5'd7, 32'hA5A5A5A5);
    setRead(1, 5'd7);
    applyStimulus("write+read x7");
    setRead(1, 5'd7);
    applyStimulus("read x7");

    reserve(5'd9); setRead(0, 5'd9);
    applyStimulus("reserve x9");
    setRead(0, 5'd9);
    applyStimulus("busy x9");
    setWrite(0, 5'd9, 32'h00000909); reserve(5'd9); setRead(2, 5'd9);
    applyStimulus("write+reserve x9");
    setWrite(1, 5'd9, 32'h00009999); setRead(2, 5'd9);
    applyStimulus("write x9");
    setRead(2, 5'd9);
    applyStimulus("idle x9");
    reserve(5'd0); setWrite(0, 5'd0, 32'hFFFFFFFF); setWrite(2, 5'd0, 32'h1); setRead(0, 5'd0);
    applyStimulus("x0 ignored");

    setWrite(0, 5'd31, 32'h31313131); setWrite(2, 5'd31, 32'hF00DF00D); reserve(5'd31);
    applyStimulus("x31 conflict");
    setRead(0, 5'd31); setRead(1, 5'd31); setRead(2, 5'd30);
    applyStimulus("read x31");

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NW; p++) begin
        if ($urandom_range(0, 1) == 1) setWrite(p, randAddr(), XL'($urandom));
      end
      for (int p = 0; p < NR; p++) setRead(p, randAddr());
      if ($urandom_range(0, 2) == 0) reserve(randAddr());
      applyStimulus($sformatf("random %0d", n));
    end

    setWrite(0, 5'd4, 32'hCAFEF00D); reserve(5'd6); setRead(0, 5'd4); rst = 1'b1;
    applyStimulus("reset dominance");
    setRead(0, 5'd4); setRead(1, 5'd6); setRead(2, 5'd31);
    applyStimulus("after reset x4/x6");
    checkOutput("x4 cleared", rd_data[0 +: XL], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
